// File: rtl/featuremap_channel_accumulator.sv
// featuremap_channel_accumulator
// Channel-reduction stage for one output feature map: sums CHANNELS per-channel
// 3x3 convolution results through a registered adder tree, adds the map bias,
// saturates to DATA_WIDTH and tags the last pixel of each frame.
// Optional build macro: FEATUREMAP_LEAKY_RELU_EN (leaky ReLU, slope 1/8, applied
// after saturation in the same stage; latency unchanged).
//
// Handshake: a word moves across a port only on a cycle where its valid and
// ready are both high at the rising edge. Upstream must hold data_in/valid_in
// until accepted; data_out/valid_out stay stable while ready_out is low. The
// whole pipeline advances together on adv = ~valid_out | ready_out, which is
// also ready_in, so bubbles travel freely and a stalled output freezes every
// stage.
module featuremap_channel_accumulator #(
  parameter int                           CHANNELS   = 16,
  parameter int                           DATA_WIDTH = 16,
  parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0,
  parameter int                           IMG_SIZE   = 208
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic                           frame_last
);

  // Tree depth; the leaf count is padded with zeros up to P = 2^S.
  localparam int S     = $clog2(CHANNELS);
  localparam int P     = 1 << S;
  // Each adder level adds one bit, so S extra bits cover the whole tree.
  localparam int SW    = DATA_WIDTH + S;
  // One more bit so the bias addition cannot wrap either.
  localparam int BW    = SW + 1;
  localparam int FRAME = IMG_SIZE * IMG_SIZE;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  localparam logic signed [BW-1:0] MAX_V =
    $signed({{(BW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [BW-1:0] MIN_V =
    $signed({{(BW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  logic                  adv;
  logic signed [SW-1:0]  tree_sum;
  logic                  tree_valid;
  logic signed [BW-1:0]  biased;
  logic [DATA_WIDTH-1:0] sat_val;
  logic [DATA_WIDTH-1:0] act_val;
  logic [CW-1:0]         count;

  assign adv      = ~valid_out | ready_out;
  assign ready_in = adv;

  generate
    if (S == 0) begin : g_single
      // A single channel needs no adder levels; it feeds the bias stage directly.
      assign tree_sum   = SW'($signed(data_in[DATA_WIDTH-1:0]));
      assign tree_valid = valid_in;
    end else begin : g_tree
      logic signed [SW-1:0] leaf [P];
      // node[k] holds the registered outputs of adder level k+1.
      logic signed [SW-1:0] node [S][P];
      logic [S-1:0]         vld;

      // Sign-extend each channel to tree width; pad the unused leaves with zero.
      always_comb begin
        for (int i = 0; i < P; i++) begin
          leaf[i] = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
          leaf[i] = SW'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
        end
      end

      // Adder levels and their valid bits, all advancing on adv.
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          vld <= '0;
          for (int k = 0; k < S; k++) begin
            for (int i = 0; i < P; i++) begin
              node[k][i] <= '0;
            end
          end
        end else if (adv) begin
          vld[0] <= valid_in;
          for (int i = 0; i < P / 2; i++) begin
            node[0][i] <= leaf[2*i] + leaf[2*i+1];
          end
          for (int k = 1; k < S; k++) begin
            vld[k] <= vld[k-1];
            for (int i = 0; i < (P >> (k + 1)); i++) begin
              node[k][i] <= node[k-1][2*i] + node[k-1][2*i+1];
            end
          end
        end
      end

      assign tree_sum   = node[S-1][0];
      assign tree_valid = vld[S-1];
    end
  endgenerate

  // Bias add at full width, clamp to the output range, then optional activation.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] sat_s;
    biased = BW'(tree_sum) + BW'(BIAS);
    if (biased > MAX_V) begin
      sat_val = MAX_V[DATA_WIDTH-1:0];
    end else if (biased < MIN_V) begin
      sat_val = MIN_V[DATA_WIDTH-1:0];
    end else begin
      sat_val = biased[DATA_WIDTH-1:0];
    end
    sat_s   = sat_val;
    act_val = sat_val;
`ifdef FEATUREMAP_LEAKY_RELU_EN
    if (sat_s < 0) begin
      act_val = sat_s >>> 3;
    end
`else
    if (sat_s < 0) begin
      act_val = sat_val;
    end
`endif
  end

  // Output register: last pipeline stage, frozen while downstream stalls.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (adv) begin
      data_out  <= act_val;
      valid_out <= tree_valid;
    end
  end

  // Pixel position within the frame; moves only on an output transfer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (valid_out && ready_out) begin
      count <= (count == LAST_IDX) ? '0 : count + 1'b1;
    end
  end

  assign frame_last = valid_out & (count == LAST_IDX);

endmodule

// File: tb/tb_featuremap_channel_accumulator.sv
// Directed bench for featuremap_channel_accumulator. Two instances share the
// stimulus: u_a with BIAS=0 and u_b with BIAS=16'h0100, both CHANNELS=16,
// DATA_WIDTH=16, IMG_SIZE=4.
module tb_featuremap_channel_accumulator;

  localparam int CH  = 16;
  localparam int DW  = 16;
  localparam int IMG = 4;
  localparam int VW  = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;

  logic          a_ready_in, a_valid_out, a_frame_last;
  logic [DW-1:0] a_data_out;
  logic          b_ready_in, b_valid_out, b_frame_last;
  logic [DW-1:0] b_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  featuremap_channel_accumulator #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .BIAS(16'sh0000), .IMG_SIZE(IMG)
  ) u_a (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_in(a_ready_in), .data_out(a_data_out), .valid_out(a_valid_out),
    .ready_out(ready_out), .frame_last(a_frame_last)
  );

  featuremap_channel_accumulator #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .BIAS(16'sh0100), .IMG_SIZE(IMG)
  ) u_b (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_in(b_ready_in), .data_out(b_data_out), .valid_out(b_valid_out),
    .ready_out(ready_out), .frame_last(b_frame_last)
  );

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = v;
    return r;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [VW-1:0] vec);
    logic acc;
    int t;
    @(posedge clk);
    #1;
    data_in = vec; valid_in = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc && t < 50) begin
      @(negedge clk); acc = a_ready_in; @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (!acc) begin n_fail++; $display("FAIL send_accept: got not-accepted expected accepted"); end
    valid_in = 1'b0; data_in = fill(16'h5A5A);
  endtask

  // Streams count pixels, all channels = base+i; expected u_a sum = 16*(base+i).
  task automatic drive_stream(input int count, input int base);
    logic acc;
    int t;
    @(posedge clk);
    #1;
    for (int i = 0; i < count; i++) begin
      data_in = fill(DW'(base + i)); valid_in = 1'b1;
      exp_q.push_back(DW'(16 * (base + i)));
      acc = 1'b0; t = 0;
      while (!acc && t < 50) begin
        @(negedge clk); acc = a_ready_in; @(posedge clk); #1; t++;
      end
      n_cmp++;
      if (!acc) begin n_fail++; $display("FAIL stream_accept: pixel %0d got not-accepted expected accepted", i); end
    end
    valid_in = 1'b0; data_in = fill(16'hDEAD);
  endtask

  // scenarios
  task automatic test_reset();
    #12;
    n_cmp++;
    if ({a_valid_out, a_frame_last, a_ready_in, a_data_out} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL reset_a: got v=%b fl=%b rdy=%b d=%h expected v=0 fl=0 rdy=1 d=0000",
                         a_valid_out, a_frame_last, a_ready_in, a_data_out);
    end
    n_cmp++;
    if ({b_valid_out, b_frame_last, b_ready_in, b_data_out} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL reset_b: got v=%b fl=%b rdy=%b d=%h expected v=0 fl=0 rdy=1 d=0000",
                         b_valid_out, b_frame_last, b_ready_in, b_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_valid_out, a_ready_in} !== 2'b01) begin
      n_fail++; $display("FAIL reset_release: got v=%b rdy=%b expected v=0 rdy=1", a_valid_out, a_ready_in);
    end
  endtask

  task automatic test_latency();
    @(posedge clk);
    #1;
    data_in = fill(16'h0001); valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0; data_in = fill(16'h1234);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_valid_out !== (k == 5)) begin
        n_fail++; $display("FAIL latency_valid_a: cycle %0d got %b expected %b", k, a_valid_out, (k == 5));
      end
      n_cmp++;
      if (b_valid_out !== (k == 5)) begin
        n_fail++; $display("FAIL latency_valid_b: cycle %0d got %b expected %b", k, b_valid_out, (k == 5));
      end
      if (k == 5) begin
        n_cmp++;
        if (a_data_out !== 16'h0010) begin
          n_fail++; $display("FAIL latency_data_a: got %h expected 0010", a_data_out);
        end
        n_cmp++;
        if (b_data_out !== 16'h0110) begin
          n_fail++; $display("FAIL latency_data_b: got %h expected 0110", b_data_out);
        end
      end
    end
  endtask

  task automatic test_bias_saturation();
    logic [VW-1:0] vecs [8];
    logic [DW-1:0] ea [8];
    logic [DW-1:0] eb [8];
    logic seen;
    for (int i = 0; i < 8; i++) vecs[i] = '0;
    vecs[0] = fill(16'h7FFF);                       ea[0] = 16'h7FFF; eb[0] = 16'h7FFF;
    vecs[1] = fill(16'h8000);
    for (int c = 0; c < CH; c++) vecs[2][c*DW +: DW] = DW'(c - 8);   // sum -8
    vecs[3][DW-1:0] = 16'hFFC0;                                       // sum -64
    vecs[4][DW-1:0] = 16'h0040;                     ea[4] = 16'h0040; eb[4] = 16'h0140;
    vecs[5][DW-1:0] = 16'h7EFF;                     ea[5] = 16'h7EFF; eb[5] = 16'h7FFF;
    vecs[6][DW-1:0] = 16'h8000;
    vecs[7][DW-1:0] = 16'h7FFF; vecs[7][2*DW-1:DW] = 16'h7FFF;  ea[7] = 16'h7FFF; eb[7] = 16'h7FFF;
`ifdef FEATUREMAP_LEAKY_RELU_EN
    ea[1] = 16'hF000; eb[1] = 16'hF000;
    ea[2] = 16'hFFFF; eb[2] = 16'h00F8;
    ea[3] = 16'hFFF8; eb[3] = 16'h00C0;
    ea[6] = 16'hF000; eb[6] = 16'hF020;
`else
    ea[1] = 16'h8000; eb[1] = 16'h8000;
    ea[2] = 16'hFFF8; eb[2] = 16'h00F8;
    ea[3] = 16'hFFC0; eb[3] = 16'h00C0;
    ea[6] = 16'h8000; eb[6] = 16'h8100;
`endif
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i]);
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
        @(negedge clk);
        seen = a_valid_out;
      end
      n_cmp++;
      if (!seen) begin
        n_fail++; $display("FAIL sat_timeout: vector %0d got no valid_out expected valid_out", i);
      end else begin
        n_cmp++;
        if (a_data_out !== ea[i]) begin
          n_fail++; $display("FAIL sat_a: vector %0d got %h expected %h", i, a_data_out, ea[i]);
        end
        n_cmp++;
        if (b_valid_out !== 1'b1 || b_data_out !== eb[i]) begin
          n_fail++; $display("FAIL sat_b: vector %0d got v=%b %h expected v=1 %h", i, b_valid_out, b_data_out, eb[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int rx;
    logic stalled_prev;
    logic [DW-1:0] prev_data, exp;
    exp_q.delete();
    ready_out = 1'b1;
    rx = 0; stalled_prev = 1'b0; prev_data = '0;
    fork
      drive_stream(20, 1);
      begin
        repeat (8) @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 120 && rx < 20; cyc++) begin
          @(negedge clk);
          if (a_valid_out && !ready_out) begin
            n_cmp++;
            if (a_ready_in !== 1'b0) begin
              n_fail++; $display("FAIL bp_ready_in: got %b expected 0", a_ready_in);
            end
            if (stalled_prev) begin
              n_cmp++;
              if (a_data_out !== prev_data) begin
                n_fail++; $display("FAIL bp_stable: got %h expected %h", a_data_out, prev_data);
              end
            end
          end
          stalled_prev = a_valid_out && !ready_out;
          prev_data = a_data_out;
          if (a_valid_out && ready_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL bp_extra: got %h expected nothing", a_data_out);
            end else begin
              exp = exp_q.pop_front();
              if (a_data_out !== exp) begin
                n_fail++; $display("FAIL bp_data: got %h expected %h", a_data_out, exp);
              end
            end
            rx++;
          end
        end
      end
    join
    n_cmp++;
    if (rx != 20 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d out (%0d left) expected 20 out (0 left)", rx, exp_q.size());
    end
  endtask

  task automatic test_frame();
    int n;
    logic [DW-1:0] exp;
    do_reset();
    exp_q.delete();
    n = 0;
    fork
      drive_stream(36, 0);
      begin
        for (int cyc = 0; cyc < 150 && n < 36; cyc++) begin
          @(negedge clk);
          if (a_valid_out && ready_out) begin
            n++;
            n_cmp++;
            if (a_frame_last !== (n == 16 || n == 32)) begin
              n_fail++; $display("FAIL frame_last_a: transfer %0d got %b expected %b", n, a_frame_last, (n == 16 || n == 32));
            end
            n_cmp++;
            if (b_frame_last !== (n == 16 || n == 32)) begin
              n_fail++; $display("FAIL frame_last_b: transfer %0d got %b expected %b", n, b_frame_last, (n == 16 || n == 32));
            end
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
            n_cmp++;
            if (a_data_out !== exp) begin
              n_fail++; $display("FAIL frame_data: transfer %0d got %h expected %h", n, a_data_out, exp);
            end
          end
        end
      end
    join
    n_cmp++;
    if (n != 36) begin
      n_fail++; $display("FAIL frame_count: got %0d expected 36", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [DW-1:0] exp;
    exp_q.delete();
    ready_out = 1'b1;
    drive_stream(6, 100);
    n_cmp++;
    if (a_valid_out !== 1'b1) begin
      n_fail++; $display("FAIL rst_preload: got %b expected 1", a_valid_out);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_valid_out, a_frame_last, a_ready_in, a_data_out} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL rst_async: got v=%b fl=%b rdy=%b d=%h expected v=0 fl=0 rdy=1 d=0000",
                         a_valid_out, a_frame_last, a_ready_in, a_data_out);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_valid_out, b_valid_out} !== 2'b00) begin
      n_fail++; $display("FAIL rst_hold: got %b%b expected 00", a_valid_out, b_valid_out);
    end
    rst_n = 1'b1;
    n = 0;
    fork
      drive_stream(16, 40);
      begin
        for (int cyc = 0; cyc < 40; cyc++) begin
          @(negedge clk);
          if (a_valid_out && ready_out) begin
            n++;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rst_extra: got %h expected nothing", a_data_out);
            end else begin
              exp = exp_q.pop_front();
              if (a_data_out !== exp) begin
                n_fail++; $display("FAIL rst_data: transfer %0d got %h expected %h", n, a_data_out, exp);
              end
            end
            n_cmp++;
            if (a_frame_last !== (n == 16)) begin
              n_fail++; $display("FAIL rst_frame_last: transfer %0d got %b expected %b", n, a_frame_last, (n == 16));
            end
          end
        end
      end
    join
    n_cmp++;
    if (n != 16) begin
      n_fail++; $display("FAIL rst_count: got %0d expected 16", n);
    end
  endtask

  // sequence and final report
  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; data_in = '0;
    test_reset();
    test_latency();
    test_bias_saturation();
    test_backpressure();
    test_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
